// File: rtl/ipsxe_floating_point_axis_fifo_ctrl_v1_0.sv
// ipsxe_floating_point_axis_fifo_ctrl_v1_0
// AXI-stream FIFO controller driving an external dual-port SRAM. Input beats
// are written straight into the SRAM; words are read back into a registered
// first-word-fall-through output stage.
// Optional macro FLT_FIFO_ALMOST_FULL_EN adds the registered o_almost_full
// output (next SRAM occupancy >= DEPTH-1).
module ipsxe_floating_point_axis_fifo_ctrl_v1_0 #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  i_aclk,
   input  logic                  i_rst,
   input  logic [DATA_WIDTH-1:0] i_s_axis_tdata,
   input  logic                  i_s_axis_tvalid,
   output logic                  o_s_axis_tready,
   output logic [DATA_WIDTH-1:0] o_m_axis_tdata,
   output logic                  o_m_axis_tvalid,
   input  logic                  i_m_axis_tready,
   output logic [DATA_WIDTH-1:0] o_sram_d,
   output logic [ADDR_WIDTH-1:0] o_sram_wa,
   output logic                  o_sram_we,
   output logic [ADDR_WIDTH-1:0] o_sram_ra,
   output logic                  o_sram_re,
   input  logic [DATA_WIDTH-1:0] i_sram_q,
`ifdef FLT_FIFO_ALMOST_FULL_EN
   output logic                  o_almost_full,
`endif
   output logic [ADDR_WIDTH:0]   o_count,
   output logic                  o_empty
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0]         DEPTH_C    = CW'(DEPTH);
   localparam logic [CW-1:0]         DEPTH_M1_C = CW'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_PTR   = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {S_EMPTY = 1'b0, S_VALID = 1'b1} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         mem_cnt_q, mem_cnt_d;
   logic [DATA_WIDTH-1:0] tdata_q;
   logic                  out_valid;
   logic                  wr;
   logic                  rd;

   // Handshake decode: ready depends only on SRAM occupancy, never on a pop
   always_comb begin
      o_s_axis_tready = !i_rst && (mem_cnt_q < DEPTH_C);
      wr = i_s_axis_tvalid && o_s_axis_tready;
      rd = !i_rst && (mem_cnt_q != '0) && (!out_valid || i_m_axis_tready);
   end

   // Pointer and occupancy next-state; pointers wrap at DEPTH-1
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      mem_cnt_d = mem_cnt_q;
      if (wr) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (rd) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      case ({wr, rd})
         2'b10:   mem_cnt_d = mem_cnt_q + 1'b1;
         2'b01:   mem_cnt_d = mem_cnt_q - 1'b1;
         default: mem_cnt_d = mem_cnt_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge i_aclk) begin
      if (i_rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         mem_cnt_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         mem_cnt_q <= mem_cnt_d;
      end
   end

   // Output stage state register
   always_ff @(posedge i_aclk) begin
      if (i_rst) state_q <= S_EMPTY;
      else       state_q <= state_d;
   end

   // Output stage next state: a read refills the register with no bubble
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_EMPTY: if (rd) state_d = S_VALID;
         S_VALID: if (i_m_axis_tready && !rd) state_d = S_EMPTY;
         default: state_d = S_EMPTY;
      endcase
   end

   // Output stage outputs
   always_comb begin
      out_valid       = (state_q == S_VALID);
      o_m_axis_tvalid = out_valid;
   end

   // Output data register captures the SRAM word on every read, else holds
   always_ff @(posedge i_aclk) begin
      if (i_rst)   tdata_q <= '0;
      else if (rd) tdata_q <= i_sram_q;
   end

   // SRAM port drive and status outputs
   always_comb begin
      o_sram_we      = wr;
      o_sram_wa      = wr_ptr_q;
      o_sram_d       = i_s_axis_tdata;
      o_sram_re      = rd;
      o_sram_ra      = rd_ptr_q;
      o_m_axis_tdata = tdata_q;
      o_count        = mem_cnt_q + {{ADDR_WIDTH{1'b0}}, out_valid};
      o_empty        = (o_count == '0);
   end

`ifdef FLT_FIFO_ALMOST_FULL_EN
   logic almost_full_q;

   // Almost-full flag registered from the next SRAM occupancy
   always_ff @(posedge i_aclk) begin
      if (i_rst) almost_full_q <= 1'b0;
      else       almost_full_q <= (mem_cnt_d >= DEPTH_M1_C);
   end

   assign o_almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_ipsxe_floating_point_axis_fifo_ctrl_v1_0.sv
// Directed bench for ipsxe_floating_point_axis_fifo_ctrl_v1_0 (DEPTH=4),
// with a behavioural dual-port SRAM attached to the SRAM ports.
module tb_ipsxe_floating_point_axis_fifo_ctrl_v1_0;

   localparam int DW = 32;
   localparam int DP = 4;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] s_tdata;
   logic          s_tvalid;
   logic          s_tready;
   logic [DW-1:0] m_tdata;
   logic          m_tvalid;
   logic          m_tready;
   logic [DW-1:0] sram_d;
   logic [AW-1:0] sram_wa;
   logic          sram_we;
   logic [AW-1:0] sram_ra;
   logic          sram_re;
   logic [DW-1:0] sram_q;
   logic [AW:0]   count;
   logic          empty;
`ifdef FLT_FIFO_ALMOST_FULL_EN
   logic          almost_full;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   ipsxe_floating_point_axis_fifo_ctrl_v1_0 #(
      .DATA_WIDTH(DW), .DEPTH(DP), .ADDR_WIDTH(AW)
   ) dut (
      .i_aclk(clk),
      .i_rst(rst),
      .i_s_axis_tdata(s_tdata),
      .i_s_axis_tvalid(s_tvalid),
      .o_s_axis_tready(s_tready),
      .o_m_axis_tdata(m_tdata),
      .o_m_axis_tvalid(m_tvalid),
      .i_m_axis_tready(m_tready),
      .o_sram_d(sram_d),
      .o_sram_wa(sram_wa),
      .o_sram_we(sram_we),
      .o_sram_ra(sram_ra),
      .o_sram_re(sram_re),
      .i_sram_q(sram_q),
`ifdef FLT_FIFO_ALMOST_FULL_EN
      .o_almost_full(almost_full),
`endif
      .o_count(count),
      .o_empty(empty)
   );

   // Behavioural dual-port SRAM: synchronous write, combinational read
   logic [DW-1:0] sram_mem [0:DP-1];
   always @(posedge clk) if (sram_we) sram_mem[sram_wa] <= sram_d;
   assign sram_q = sram_re ? sram_mem[sram_ra] : '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) $display("[TB] %s ok obs=%0h", tag, obs);
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;
      step(); step();
      rst = 1'b0;
      #1;
      // Reset then idle
      check("rst_tready", s_tready, 1);
      check("rst_tvalid", m_tvalid, 0);
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_we", sram_we, 0);
      check("rst_re", sram_re, 0);
      check("rst_tdata", m_tdata, 0);

      // Single beat latency
      step();
      m_tready = 1'b1; s_tvalid = 1'b1; s_tdata = 32'h3F80_0000;
      #1;
      check("one_we", sram_we, 1);
      check("one_wa", sram_wa, 0);
      check("one_re_e", sram_re, 0);
      step();
      s_tvalid = 1'b0;
      #1;
      check("one_re", sram_re, 1);
      check("one_ra", sram_ra, 0);
      check("one_tvalid_e1", m_tvalid, 0);
      check("one_count_e1", count, 1);
      step();
      check("one_tvalid", m_tvalid, 1);
      check("one_tdata", m_tdata, 32'h3F80_0000);
      check("one_count", count, 1);
      step();
      check("one_pop_tvalid", m_tvalid, 0);
      check("one_pop_empty", empty, 1);

      // Fill with downstream stalled
      m_tready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         s_tvalid = 1'b1; s_tdata = i;
         #1;
         check($sformatf("fill_tready_%0d", i), s_tready, 1);
         step();
      end
      check("full_count", count, 5);
      check("full_tvalid", m_tvalid, 1);
      check("full_tdata", m_tdata, 1);
      s_tdata = 6;
      #1;
      check("full_tready", s_tready, 0);
      check("full_we", sram_we, 0);
      step();
      check("full_count_hold", count, 5);
      check("full_tdata_hold", m_tdata, 1);
      s_tvalid = 1'b0; m_tready = 1'b1;
      for (int k = 2; k <= 5; k++) begin
         step();
         check($sformatf("drain_tvalid_%0d", k), m_tvalid, 1);
         check($sformatf("drain_tdata_%0d", k), m_tdata, k);
      end
      step();
      check("drain_done", m_tvalid, 0);
      s_tvalid = 1'b1; s_tdata = 6;
      step();
      s_tvalid = 1'b0;
      step();
      check("six_tvalid", m_tvalid, 1);
      check("six_tdata", m_tdata, 6);
      step();
      check("six_pop", m_tvalid, 0);

      // Continuous streaming through pointer wraps
      for (int j = 0; j <= 20; j++) begin
         if (j < 20) begin
            s_tvalid = 1'b1; s_tdata = j;
         end else begin
            s_tvalid = 1'b0;
         end
         #1;
         if (j < 20) check($sformatf("strm_tready_%0d", j), s_tready, 1);
         step();
         if (j >= 1) begin
            check($sformatf("strm_tvalid_%0d", j - 1), m_tvalid, 1);
            check($sformatf("strm_tdata_%0d", j - 1), m_tdata, j - 1);
         end
      end
      step();
      check("strm_end_tvalid", m_tvalid, 0);
      check("strm_end_count", count, 0);

      // Reset mid-stream
      m_tready = 1'b0;
      s_tvalid = 1'b1; s_tdata = 32'h11; step();
      s_tdata = 32'h22; step();
      s_tdata = 32'h33; step();
      s_tvalid = 1'b0;
      check("mid_count", count, 3);
      check("mid_tdata", m_tdata, 32'h11);
      rst = 1'b1;
      #1;
      check("mid_rst_tready", s_tready, 0);
      check("mid_rst_re", sram_re, 0);
      step();
      rst = 1'b0;
      check("mid_rst_count", count, 0);
      check("mid_rst_tvalid", m_tvalid, 0);
      check("mid_rst_tdata", m_tdata, 0);
      check("mid_rst_empty", empty, 1);
      m_tready = 1'b1; s_tvalid = 1'b1; s_tdata = 32'hA5;
      step();
      s_tvalid = 1'b0;
      step();
      check("post_rst_tvalid", m_tvalid, 1);
      check("post_rst_tdata", m_tdata, 32'hA5);
      step();
      check("post_rst_pop", m_tvalid, 0);

`ifdef FLT_FIFO_ALMOST_FULL_EN
      // Almost-full tracks SRAM occupancy reaching DEPTH-1
      m_tready = 1'b0;
      check("af_idle", almost_full, 0);
      for (int i = 1; i <= 4; i++) begin
         s_tvalid = 1'b1; s_tdata = i;
         step();
      end
      s_tvalid = 1'b0;
      check("af_count", count, 4);
      check("af_rise", almost_full, 1);
      m_tready = 1'b1;
      step();
      check("af_fall", almost_full, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
